// File: rtl/led_frame_router.sv
`default_nettype none
// ============================================================================
//  Module      : led_frame_router
//  Description : Parses {address, data} frames from a UART byte stream into
//                one-cycle write strobes for NUM_CH LED pixel-buffer channels.
//                Optional checksum byte: LED_FRAME_ROUTER_CHECKSUM_EN.
//  Revision    : 1.0
// ============================================================================
module led_frame_router #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic [NUM_CH*8*DATA_BYTES-1:0] led_data,
    output logic [NUM_CH*8*ADDR_BYTES-1:0] led_addr,
    output logic [NUM_CH-1:0]              led_write,
    output logic                           frame_err,
    output logic                           busy
);

    localparam int c_addr_w = 8 * ADDR_BYTES;
    localparam int c_data_w = 8 * DATA_BYTES;
    localparam int c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_to_w   = $clog2(TIMEOUT + 1);

    localparam logic [2:0]          c_addr_last = 3'(ADDR_BYTES - 1);
    localparam logic [2:0]          c_data_last = 3'(DATA_BYTES - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);
    localparam logic [c_ch_w:0]     c_num_ch    = (c_ch_w + 1)'(NUM_CH);
    // With a single channel there is no channel field, so the address passes through.
    localparam logic [c_addr_w-1:0] c_ch_mask   = (NUM_CH > 1) ?
        {{c_ch_w{1'b1}}, {(c_addr_w - c_ch_w){1'b0}}} : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_byte_cnt;
    logic [c_addr_w-1:0]   r_addr;
    logic [c_data_w-1:0]   r_data;
    logic [c_to_w-1:0]     r_to_cnt;

    logic [c_addr_w-1:0]   w_addr_next;
    logic [c_data_w-1:0]   w_data_next;
    logic [c_data_w-1:0]   w_frame_data;
    logic [c_ch_w-1:0]     w_ch;
    logic                  w_ch_ok;
    logic                  w_done;
    logic                  w_good;
    logic                  w_commit_ok;
    logic                  w_commit_err;

    // Current byte dropped into its little-endian slot of the field being assembled.
    always_comb begin
        w_addr_next = r_addr;
        w_data_next = r_data;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (r_byte_cnt == 3'(i)) w_addr_next[8*i +: 8] = rx_data;
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_byte_cnt == 3'(i)) w_data_next[8*i +: 8] = rx_data;
        end
    end

    assign w_ch    = (NUM_CH > 1) ? r_addr[c_addr_w-1 -: c_ch_w] : '0;
    assign w_ch_ok = ({1'b0, w_ch} < c_num_ch);

`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
    logic [7:0] r_csum;

    assign w_done       = rx_valid && (r_state == S_CSUM);
    assign w_good       = (rx_data == r_csum);
    assign w_frame_data = r_data;
`else
    assign w_done       = rx_valid && (r_state == S_DATA) && (r_byte_cnt == c_data_last);
    assign w_good       = 1'b1;
    assign w_frame_data = w_data_next;
`endif

    assign w_commit_ok  = w_done && w_good && w_ch_ok;
    assign w_commit_err = w_done && !(w_good && w_ch_ok);
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_to_cnt   <= '0;
            led_data   <= '0;
            led_addr   <= '0;
            led_write  <= '0;
            frame_err  <= 1'b0;
`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            led_write <= '0;
            frame_err <= 1'b0;

            if (rx_valid) begin
                // A byte always wins over a timeout expiring in the same cycle.
                r_to_cnt <= '0;
`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
                r_csum   <= (r_state == S_IDLE) ? rx_data : (r_csum ^ rx_data);
`endif
                case (r_state)
                    S_IDLE: begin
                        r_addr <= c_addr_w'(rx_data);
                        if (ADDR_BYTES == 1) begin
                            r_state    <= S_DATA;
                            r_byte_cnt <= '0;
                        end else begin
                            r_state    <= S_ADDR;
                            r_byte_cnt <= 3'd1;
                        end
                    end
                    S_ADDR: begin
                        r_addr <= w_addr_next;
                        if (r_byte_cnt == c_addr_last) begin
                            r_state    <= S_DATA;
                            r_byte_cnt <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                    S_DATA: begin
                        r_data <= w_data_next;
                        if (r_byte_cnt == c_data_last) begin
                            r_byte_cnt <= '0;
`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_IDLE;
`endif
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_byte_cnt <= '0;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == c_to_last) begin
                    r_state    <= S_IDLE;
                    r_byte_cnt <= '0;
                    r_to_cnt   <= '0;
                    frame_err  <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end

            for (int k = 0; k < NUM_CH; k++) begin
                if (w_commit_ok && (w_ch == c_ch_w'(k))) begin
                    led_data[k*c_data_w +: c_data_w] <= w_frame_data;
                    led_addr[k*c_addr_w +: c_addr_w] <= r_addr & ~c_ch_mask;
                    led_write[k]                     <= 1'b1;
                end
            end
            if (w_commit_err) frame_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_frame_router
//  Description : Randomized scoreboard bench for led_frame_router with a
//                frame-level reference model (NUM_CH=3 exercises range errors).
//  Revision    : 1.0
// ============================================================================
module tb_led_frame_router;

    localparam int NUM_CH  = 3;
    localparam int TIMEOUT = 20;
    localparam int CH_W    = 2;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic [7:0]           rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic [NUM_CH*32-1:0] led_data;
    logic [NUM_CH*32-1:0] led_addr;
    logic [NUM_CH-1:0]    led_write;
    logic                 frame_err;
    logic                 busy;

    led_frame_router #(
        .NUM_CH(NUM_CH), .ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .led_data(led_data), .led_addr(led_addr), .led_write(led_write),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        int          ch;
        logic [31:0] addr;
        logic [31:0] data;
        longint      cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_addr[NUM_CH];
    logic [31:0] mdl_data[NUM_CH];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops expectations when the DUT presents a strobe, tracks held registers.
    always @(negedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                mdl_addr[k] = '0;
                mdl_data[k] = '0;
            end
            n_checks++;
            if (led_write != '0 || frame_err || led_data != '0 || led_addr != '0 || busy) begin
                n_fail++;
                $display("FAIL reset_outputs: got write=%b err=%b busy=%b data=%h addr=%h, expected all zero",
                         led_write, frame_err, busy, led_data, led_addr);
            end
        end else begin
            n_checks++;
            if ($countones(led_write) > 1) begin
                n_fail++;
                $display("FAIL write_onehot: got led_write=%b, expected at most one bit", led_write);
            end
            if (led_write != '0 || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got write=%b err=%b at cycle %0d, expected nothing",
                             led_write, frame_err, cyc);
                end else begin
                    exp_t e;
                    logic [NUM_CH-1:0] onehot;
                    e = exp_q.pop_front();
                    onehot = '0;
                    if (!e.is_err) onehot[e.ch] = 1'b1;
                    n_checks++;
                    if (led_write != onehot || frame_err != e.is_err || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL frame_result: got write=%b err=%b cycle=%0d, expected write=%b err=%b cycle=%0d",
                                 led_write, frame_err, cyc, onehot, e.is_err, e.cyc);
                    end
                    if (!e.is_err) begin
                        mdl_addr[e.ch] = e.addr;
                        mdl_data[e.ch] = e.data;
                    end
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_output: got no strobe by cycle %0d, expected one at cycle %0d",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < NUM_CH; k++) begin
                n_checks++;
                if (led_data[k*32 +: 32] != mdl_data[k] || led_addr[k*32 +: 32] != mdl_addr[k]) begin
                    n_fail++;
                    $display("FAIL channel_regs ch%0d: got data=%h addr=%h, expected data=%h addr=%h",
                             k, led_data[k*32 +: 32], led_addr[k*32 +: 32], mdl_data[k], mdl_addr[k]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (gap) @(negedge clock);
    endtask

    // Reference model: frame bytes, channel and outcome computed from the frame rules.
    task automatic send_frame(input logic [31:0] addr, input logic [31:0] data,
                              input bit bad_csum, input int maxgap, input int long_idx);
        logic [7:0] fb[$];
        logic [7:0] x;
        exp_t       e;
        int         ch;
        for (int i = 0; i < 4; i++) fb.push_back(8'(addr >> (8*i)));
        for (int i = 0; i < 4; i++) fb.push_back(8'(data >> (8*i)));
`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
        x = '0;
        foreach (fb[i]) x = x ^ fb[i];
        if (bad_csum) x = x ^ 8'(1 + $urandom_range(0, 254));
        fb.push_back(x);
`else
        x = '0;
        if (bad_csum) x = 8'd1;
`endif
        ch       = int'(addr >> (32 - CH_W));
        e.is_err = (x != 8'd0 && bad_csum) || (ch >= NUM_CH);
        e.ch     = ch;
        e.addr   = addr % (32'd1 << (32 - CH_W));
        e.data   = data;
`ifndef LED_FRAME_ROUTER_CHECKSUM_EN
        e.is_err = (ch >= NUM_CH);
`endif
        for (int i = 0; i < fb.size(); i++) begin
            int g;
            g = (i == long_idx) ? TIMEOUT - 1 : int'($urandom_range(0, maxgap));
            if (i == fb.size() - 1) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            send_byte(fb[i], g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected end of stimulus", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint c_last;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        send_frame(32'h0000_0005, 32'h4433_2211, 1'b0, 0, -1);
        send_frame(32'h4000_0007, 32'hDDCC_BBAA, 1'b0, 0, -1);
        send_frame(32'h8012_3456, 32'h0102_0304, 1'b0, 1, -1);
        send_frame(32'hC000_0001, 32'hFFFF_FFFF, 1'b0, 0, -1);
        // Byte landing on the timeout cycle must be kept.
        send_frame(32'h0000_00AB, 32'h5566_7788, 1'b0, 0, 3);
`ifdef LED_FRAME_ROUTER_CHECKSUM_EN
        send_frame(32'h0000_0001, 32'h4030_2010, 1'b0, 0, -1);
        send_frame(32'h0000_0001, 32'h4030_2010, 1'b1, 0, -1);
`endif

        // Partial frame then silence: dropped after TIMEOUT idle clocks.
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        c_last = cyc;
        send_byte(8'h00, 0);
        begin
            exp_t e;
            e.is_err = 1'b1; e.ch = 0; e.addr = '0; e.data = '0;
            e.cyc = c_last + 1 + TIMEOUT;
            exp_q.push_back(e);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_partial: got %b, expected 1", busy);
        end
        repeat (TIMEOUT + 2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_timeout: got %b, expected 0", busy);
        end
        send_frame(32'h0000_0033, 32'hCAFE_F00D, 1'b0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom();
            send_frame(a, $urandom(), ($urandom_range(0, 3) == 0), (n < 20) ? 0 : 2, -1);
        end

        // Reset in the middle of a frame: discarded silently, outputs cleared.
        repeat (2) @(negedge clock);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h77, 0);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || led_data !== '0) begin
            n_fail++;
            $display("FAIL after_reset: got busy=%b data=%h, expected 0", busy, led_data);
        end
        send_frame(32'h4000_0002, 32'h1234_5678, 1'b0, 0, -1);

        repeat (5) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
